// File: rtl/i2s_pkg.sv
// Shared I2S definitions: data word type and default FIFO depth.
package i2s_pkg;

  localparam int DATA_W        = 32;
  localparam int TX_FIFO_DEPTH = 8;

  typedef logic [DATA_W-1:0] word_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port, no reset.
module i2s_fifo_mem
  import i2s_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_tx_fifo.sv
// First-word-fall-through transmit FIFO between APB register control and the I2S serializer.
// Optional macro I2S_TXFIFO_ERR_EN adds sticky ovf_err/unf_err outputs and an err_clr input.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH    = TX_FIFO_DEPTH,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
`ifdef I2S_TXFIFO_ERR_EN
  input  logic                     err_clr,
  output logic                     ovf_err,
  output logic                     unf_err,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_nxt;
  logic [AW:0]   rd_ptr_nxt;
  logic [LW-1:0] level_nxt;
  logic          do_wr;
  logic          do_rd;
  logic          full_nxt;
  logic          empty_nxt;
  logic          af_nxt;
  logic          ae_nxt;

  // A full FIFO still accepts a write when the same edge pops the head.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr + (AW+1)'(do_wr);
    rd_ptr_nxt = rd_ptr + (AW+1)'(do_rd);
    level_nxt  = level + LW'(do_wr) - LW'(do_rd);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                 (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    af_nxt     = (level_nxt >= LW'(AF_LEVEL));
    ae_nxt     = (level_nxt <= LW'(AE_LEVEL));
  end

  // Pointers and all status flags share one register stage so they never disagree.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      empty        <= empty_nxt;
      full         <= full_nxt;
      almost_empty <= ae_nxt;
      almost_full  <= af_nxt;
    end
  end

`ifdef I2S_TXFIFO_ERR_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = wr_en && full && !rd_en;
  assign unf_set = rd_en && empty;

  // Set wins over a clear arriving on the same edge.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set || (ovf_err && !err_clr);
      unf_err <= unf_set || (unf_err && !err_clr);
    end
  end
`endif

  i2s_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (pclk),
    .we    (do_wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Scoreboard bench for i2s_tx_fifo (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_i2s_tx_fifo;

  logic        pclk;
  logic        preset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  level;
`ifdef I2S_TXFIFO_ERR_EN
  logic        err_clr;
  logic        ovf_err;
  logic        unf_err;
`endif

  int checks;
  int errors;
  logic [31:0] sb[$];
  logic [31:0] exp_w;

  i2s_tx_fifo #(
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .pclk         (pclk),
    .preset       (preset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef I2S_TXFIFO_ERR_EN
    .err_clr      (err_clr),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err),
`endif
    .level        (level)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Drive one cycle of stimulus; returns 1 ns after the edge with inputs idle.
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge pclk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b0;
    #23;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || level !== 4'd0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got e=%b f=%b lvl=%0d ae=%b af=%b want e=1 f=0 lvl=0 ae=1 af=0",
               empty, full, level, almost_empty, almost_full);
    end
`ifdef I2S_TXFIFO_ERR_EN
    checks++;
    if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got ovf=%b unf=%b want 0 0", ovf_err, unf_err);
    end
`endif
    @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_first_write();
    step(1'b1, 32'hA5A5_0001, 1'b0);
    sb.push_back(32'hA5A5_0001);
    checks++;
    if (empty !== 1'b0 || level !== 4'd1 || rd_data !== sb[0]) begin
      errors++;
      $display("FAIL first_write got e=%b lvl=%0d data=%h want e=0 lvl=1 data=%h",
               empty, level, rd_data, sb[0]);
    end
    exp_w = sb.pop_front();
    checks++;
    if (rd_data !== exp_w) begin
      errors++;
      $display("FAIL first_pop got %h want %h", rd_data, exp_w);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (empty !== 1'b1 || level !== 4'd0) begin
      errors++;
      $display("FAIL first_empty got e=%b lvl=%0d want e=1 lvl=0", empty, level);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 1'b0);
      sb.push_back(32'(i));
      checks++;
      if (level !== 4'(sb.size()) || almost_full !== (sb.size() >= 6) ||
          almost_empty !== (sb.size() <= 2) || full !== (sb.size() == 8)) begin
        errors++;
        $display("FAIL fill_%0d got lvl=%0d af=%b ae=%b f=%b want lvl=%0d af=%b ae=%b f=%b",
                 i, level, almost_full, almost_empty, full, sb.size(),
                 sb.size() >= 6, sb.size() <= 2, sb.size() == 8);
      end
    end
    step(1'b1, 32'hDEAD, 1'b0);
    checks++;
    if (full !== 1'b1 || level !== 4'd8 || rd_data !== sb[0]) begin
      errors++;
      $display("FAIL drop_write got f=%b lvl=%0d head=%h want f=1 lvl=8 head=%h",
               full, level, rd_data, sb[0]);
    end
`ifdef I2S_TXFIFO_ERR_EN
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_err got %b want 1", ovf_err);
    end
    err_clr = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    err_clr = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b want 0", ovf_err);
    end
`endif
  endtask

  task automatic test_drain();
    while (sb.size() > 0) begin
      exp_w = sb.pop_front();
      checks++;
      if (rd_data !== exp_w) begin
        errors++;
        $display("FAIL drain_data got %h want %h", rd_data, exp_w);
      end
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (level !== 4'(sb.size()) || almost_empty !== (sb.size() <= 2) ||
          empty !== (sb.size() == 0) || full !== 1'b0) begin
        errors++;
        $display("FAIL drain_flags got lvl=%0d ae=%b e=%b f=%b want lvl=%0d ae=%b e=%b f=0",
                 level, almost_empty, empty, full, sb.size(), sb.size() <= 2, sb.size() == 0);
      end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (level !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow got lvl=%0d e=%b want lvl=0 e=1", level, empty);
    end
`ifdef I2S_TXFIFO_ERR_EN
    checks++;
    if (unf_err !== 1'b1) begin
      errors++;
      $display("FAIL unf_err got %b want 1", unf_err);
    end
    err_clr = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    err_clr = 1'b0;
    checks++;
    if (unf_err !== 1'b1) begin
      errors++;
      $display("FAIL unf_set_prio got %b want 1", unf_err);
    end
    err_clr = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    err_clr = 1'b0;
`endif
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b0);
      sb.push_back(32'h100 + 32'(i));
    end
    exp_w = sb.pop_front();
    checks++;
    if (rd_data !== exp_w) begin
      errors++;
      $display("FAIL full_rw_head got %h want %h", rd_data, exp_w);
    end
    step(1'b1, 32'hBEEF, 1'b1);
    sb.push_back(32'hBEEF);
    checks++;
    if (level !== 4'd8 || full !== 1'b1 || rd_data !== sb[0]) begin
      errors++;
      $display("FAIL full_rw got lvl=%0d f=%b head=%h want lvl=8 f=1 head=%h",
               level, full, rd_data, sb[0]);
    end
    test_drain();
  endtask

  task automatic test_empty_rw();
    step(1'b1, 32'h00C0_FFEE, 1'b1);
    sb.push_back(32'h00C0_FFEE);
    checks++;
    if (level !== 4'd1 || empty !== 1'b0 || rd_data !== sb[0]) begin
      errors++;
      $display("FAIL empty_rw got lvl=%0d e=%b data=%h want lvl=1 e=0 data=%h",
               level, empty, rd_data, sb[0]);
    end
    test_drain();
  endtask

  task automatic test_wrap();
    logic r;
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      d = 32'h5000_0000 + 32'($urandom_range(0, 16'hFFFF));
      r = (i % 3 != 0) && (sb.size() > 0);
      if (r) begin
        exp_w = sb.pop_front();
        checks++;
        if (rd_data !== exp_w) begin
          errors++;
          $display("FAIL wrap_data_%0d got %h want %h", i, rd_data, exp_w);
        end
      end
      step(1'b1, d, r);
      sb.push_back(d);
    end
    checks++;
    if (level !== 4'(sb.size())) begin
      errors++;
      $display("FAIL wrap_level got %0d want %0d", level, sb.size());
    end
    test_drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0A00 + 32'(i), 1'b0);
    end
    #2;
    preset = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || level !== 4'd0 || full !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got e=%b lvl=%0d f=%b ae=%b want e=1 lvl=0 f=0 ae=1",
               empty, level, full, almost_empty);
    end
    @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk);
    #1;
    step(1'b1, 32'h0000_0077, 1'b0);
    checks++;
    if (rd_data !== 32'h0000_0077 || level !== 4'd1 || dut.u_mem.mem[0] !== 32'h0000_0077) begin
      errors++;
      $display("FAIL post_reset_write got data=%h lvl=%0d mem0=%h want 77 1 77",
               rd_data, level, dut.u_mem.mem[0]);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
`ifdef I2S_TXFIFO_ERR_EN
    err_clr = 1'b0;
`endif
    test_reset();
    test_first_write();
    test_fill();
    test_drain();
    test_underflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
